// File: rtl/crtc_arb_pkg.sv
// Shared encodings for the CRTC / CPU video RAM arbiter.
package crtc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VID      = 3'd1,
    CPU_RD   = 3'd2,
    CPU_WR   = 3'd3,
    CPU_RESP = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  localparam int VID_LATENCY = 3;

endpackage

// File: rtl/crtc_arb_rdpipe.sv
// Two-stage owner tag pipeline that steers VRAM read data to the video or CPU side.
module crtc_arb_rdpipe
  import crtc_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          CLOCK,
  input  logic          nRESET,
  input  owner_t        issue_own,
  input  logic [DW-1:0] mem_di,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_ret
);

  owner_t        tag0_r;
  owner_t        tag1_r;
  logic [DW-1:0] vid_data_r;
  logic          vid_valid_r;
  logic [DW-1:0] cpu_do_r;

  // Owner tags follow the slot through the address cycle and the RAM latency cycle.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      tag0_r <= OWN_NONE;
      tag1_r <= OWN_NONE;
    end else begin
      tag0_r <= issue_own;
      tag1_r <= tag0_r;
    end
  end

  // Each return lands only in the register of its owner, so the paths never clobber each other.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      vid_data_r  <= {DW{1'b0}};
      vid_valid_r <= 1'b0;
      cpu_do_r    <= {DW{1'b0}};
    end else begin
      vid_valid_r <= 1'b0;
      case (tag1_r)
        OWN_VID: begin
          vid_data_r  <= mem_di;
          vid_valid_r <= 1'b1;
        end
        OWN_CPU: cpu_do_r <= mem_di;
        default: vid_valid_r <= 1'b0;
      endcase
    end
  end

  assign vid_data  = vid_data_r;
  assign vid_valid = vid_valid_r;
  assign cpu_do    = cpu_do_r;
  assign cpu_ret   = (tag1_r == OWN_CPU);

endmodule

// File: rtl/crtc_vram_arbiter.sv
// Single-port VRAM arbiter: fixed-latency CRTC fetches win every slot, CPU fills the gaps.
// Optional build macro CRTC_ARB_BLANK_ONLY_EN restricts CPU slots to display blanking.
module crtc_vram_arbiter
  import crtc_arb_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          CLOCK,
  input  logic          nRESET,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_ADDR,
  output logic [DW-1:0] VID_DATA,
  output logic          VID_VALID,
  input  logic          DISP_EN,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_DI,
  output logic [DW-1:0] CPU_DO,
  output logic          CPU_ACK,
  output logic          CPU_WAIT,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_DO,
  input  logic [DW-1:0] MEM_DI
);

  arb_state_t    state_r;
  arb_state_t    state_nxt_s;
  owner_t        issue_own_s;
  logic          blank_ok_s;
  logic          cpu_elig_s;
  logic          cpu_busy_r;
  logic          cpu_ret_s;
  logic          ack_nxt_s;
  logic          cpu_ack_r;
  logic [AW-1:0] mem_addr_r;
  logic          mem_we_r;
  logic [DW-1:0] mem_do_r;

`ifdef CRTC_ARB_BLANK_ONLY_EN
  assign blank_ok_s = ~DISP_EN;
`else
  logic disp_unused_s;
  assign disp_unused_s = DISP_EN;
  assign blank_ok_s    = 1'b1;
`endif

  // The ACK cycle is masked so a still-high CPU_REQ cannot reissue the finished access.
  assign cpu_elig_s = CPU_REQ & ~cpu_busy_r & ~cpu_ack_r & blank_ok_s;

  // Slot owner selection and next state: video, then CPU, then idle.
  always_comb begin
    state_nxt_s = IDLE;
    issue_own_s = OWN_NONE;
    if (VID_REQ) begin
      state_nxt_s = VID;
      issue_own_s = OWN_VID;
    end else if (cpu_elig_s) begin
      state_nxt_s = CPU_WE ? CPU_WR : CPU_RD;
      issue_own_s = CPU_WE ? OWN_NONE : OWN_CPU;
    end else if (state_r == CPU_RD) begin
      state_nxt_s = CPU_RESP;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  assign ack_nxt_s = cpu_ret_s | (state_r == CPU_WR);

  // FSM state register.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered memory port; address and write data hold when no one owns the slot.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      mem_addr_r <= {AW{1'b0}};
      mem_we_r   <= 1'b0;
      mem_do_r   <= {DW{1'b0}};
    end else if (VID_REQ) begin
      mem_addr_r <= VID_ADDR;
      mem_we_r   <= 1'b0;
    end else if (cpu_elig_s) begin
      mem_addr_r <= CPU_ADDR;
      mem_we_r   <= CPU_WE;
      mem_do_r   <= CPU_DI;
    end else begin
      mem_we_r   <= 1'b0;
    end
  end

  // CPU in-flight flag and completion strobe.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      cpu_busy_r <= 1'b0;
      cpu_ack_r  <= 1'b0;
    end else begin
      cpu_ack_r <= ack_nxt_s;
      if (cpu_elig_s && !VID_REQ) begin
        cpu_busy_r <= 1'b1;
      end else if (ack_nxt_s) begin
        cpu_busy_r <= 1'b0;
      end else begin
        cpu_busy_r <= cpu_busy_r;
      end
    end
  end

  crtc_arb_rdpipe #(.DW(DW)) u_rdpipe (
    .CLOCK     (CLOCK),
    .nRESET    (nRESET),
    .issue_own (issue_own_s),
    .mem_di    (MEM_DI),
    .vid_data  (VID_DATA),
    .vid_valid (VID_VALID),
    .cpu_do    (CPU_DO),
    .cpu_ret   (cpu_ret_s)
  );

  assign MEM_ADDR = mem_addr_r;
  assign MEM_WE   = mem_we_r;
  assign MEM_DO   = mem_do_r;
  assign CPU_ACK  = cpu_ack_r;
  assign CPU_WAIT = CPU_REQ & ~cpu_ack_r;

endmodule
